// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to the external combinational 32-bit ALU.
// It chains up to three ALU passes to build 64-bit ADD/SUB, and folds the
// low-word carry in with a +1/-1 correction pass.
// Optional build macro ALU_SEQ_STICKY_EN adds the clr_sticky input and the
// sticky_ovf/sticky_carry outputs.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PASS1 | low word (or the only word) on the ALU
// PASS2 | high word on the ALU
// PASS3 | carry/borrow correction of the high word (+1 / -1)
// RESP  | response held on rsp_* until rsp_ready
module alu_cmd_sequencer #(
  parameter int ALU_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [31:0] cmd_a_hi,
  input  logic [31:0] cmd_b_hi,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_carry,
  output logic        rsp_overflow,
`ifdef ALU_SEQ_STICKY_EN
  input  logic        clr_sticky,
  output logic        sticky_ovf,
  output logic        sticky_carry,
`endif
  output logic        rsp_err
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_ILL   = 3'b100;
  localparam logic [2:0] OP_ADD64 = 3'b110;

  localparam int CW = (ALU_WAIT > 0) ? $clog2(ALU_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(ALU_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS1,
    S_PASS2,
    S_PASS3,
    S_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_hi_q, b_hi_q, lo_q;
  logic          c0_q, c1_q;
  logic          is64, is_sub, pass_done, need_p3, in_pass, ovf64;

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    in_pass   = (state == S_PASS1) || (state == S_PASS2) || (state == S_PASS3);
    pass_done = (wait_cnt == '0);
    is64      = (op_q[2:1] == 2'b11);
    is_sub    = op_q[0];
    // ADD64 needs +1 when the low word carried; SUB64 needs -1 when it borrowed.
    need_p3   = (op_q == OP_ADD64) ? c0_q : ~c0_q;
    // The high word result is always on alu_result when a 64-bit op finishes.
    ovf64     = (is_sub ? (a_hi_q[31] != b_hi_q[31]) : (a_hi_q[31] == b_hi_q[31]))
                & (alu_result[31] != a_hi_q[31]);
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = (cmd_op == OP_ILL) ? S_RESP : S_PASS1;
      S_PASS1: if (pass_done) state_nxt = is64 ? S_PASS2 : S_RESP;
      S_PASS2: if (pass_done) state_nxt = need_p3 ? S_PASS3 : S_RESP;
      S_PASS3: if (pass_done) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Per-pass hold counter; reloads at the end of every pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wait_cnt <= WAIT_INIT;
    else if (in_pass && !pass_done) wait_cnt <= wait_cnt - 1'b1;
    else                            wait_cnt <= WAIT_INIT;
  end

  // Command capture, ALU operand sequencing and response assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      lo_q         <= '0;
      c0_q         <= 1'b0;
      c1_q         <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= '0;
      rsp_lo       <= '0;
      rsp_hi       <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          a_hi_q <= cmd_a_hi;
          b_hi_q <= cmd_b_hi;
          if (cmd_op == OP_ILL) begin
            rsp_lo       <= '0;
            rsp_hi       <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b1;
          end else begin
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
            alu_ctrl <= (cmd_op[2:1] == 2'b11) ? {2'b00, cmd_op[0]} : cmd_op;
          end
        end
        S_PASS1: if (pass_done) begin
          if (is64) begin
            lo_q  <= alu_result;
            c0_q  <= alu_carry;
            alu_a <= a_hi_q;
            alu_b <= b_hi_q;
          end else begin
            rsp_lo       <= alu_result;
            rsp_hi       <= '0;
            rsp_carry    <= alu_carry;
            rsp_overflow <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_overflow : 1'b0;
            rsp_err      <= 1'b0;
          end
        end
        S_PASS2: if (pass_done) begin
          if (need_p3) begin
            c1_q  <= alu_carry;
            alu_a <= alu_result;
            alu_b <= 32'd1;
          end else begin
            // Skipped correction: c2 is 0 for ADD64 and 1 for SUB64, so carry = c1.
            rsp_lo       <= lo_q;
            rsp_hi       <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= ovf64;
            rsp_err      <= 1'b0;
          end
        end
        S_PASS3: if (pass_done) begin
          rsp_lo       <= lo_q;
          rsp_hi       <= alu_result;
          rsp_carry    <= is_sub ? (c1_q & alu_carry) : (c1_q | alu_carry);
          rsp_overflow <= ovf64;
          rsp_err      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  // Sticky flags accumulate over response handshakes; clear beats set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf   <= 1'b0;
      sticky_carry <= 1'b0;
    end else if (clr_sticky) begin
      sticky_ovf   <= 1'b0;
      sticky_carry <= 1'b0;
    end else if (rsp_valid && rsp_ready) begin
      sticky_ovf   <= sticky_ovf | rsp_overflow;
      sticky_carry <= sticky_carry | rsp_carry;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed + random bench for alu_cmd_sequencer with a behavioural ALU and a
// response scoreboard built from plain 32/64-bit arithmetic.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b, cmd_a_hi, cmd_b_hi;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_overflow, alu_carry;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_carry, rsp_overflow, rsp_err;
`ifdef ALU_SEQ_STICKY_EN
  logic        clr_sticky, sticky_ovf, sticky_carry;
  logic        exp_s_ovf, exp_s_carry;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        carry;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [66:0] pass_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.ALU_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_a_hi(cmd_a_hi), .cmd_b_hi(cmd_b_hi),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow),
`ifdef ALU_SEQ_STICKY_EN
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry),
`endif
    .rsp_err(rsp_err)
  );

  // Behavioural combinational ALU.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b001: begin
        alu_result   = alu_a - alu_b;
        alu_carry    = (alu_a >= alu_b);
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: ;
    endcase
  end

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, b, ahi, bhi);
    exp_t e;
    logic [32:0] s;
    logic [64:0] s64;
    logic [63:0] aa, bb, d;
    e.lo = '0; e.hi = '0; e.carry = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 2;
    aa = {ahi, a};
    bb = {bhi, b};
    s  = {1'b0, a} + {1'b0, b};
    case (op)
      3'b000: begin
        e.lo = s[31:0]; e.carry = s[32];
        e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b001: begin
        e.lo = a - b; e.carry = (a >= b);
        e.ovf = (a[31] != b[31]) && (e.lo[31] != a[31]);
      end
      3'b010: e.lo = a & b;
      3'b011: e.lo = a ^ b;
      3'b101: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110: begin
        s64 = {1'b0, aa} + {1'b0, bb};
        {e.hi, e.lo} = s64[63:0];
        e.carry = s64[64];
        e.ovf = (aa[63] == bb[63]) && (s64[63] != aa[63]);
        e.lat = s[32] ? 4 : 3;
      end
      3'b111: begin
        d = aa - bb;
        {e.hi, e.lo} = d;
        e.carry = (aa >= bb);
        e.ovf = (aa[63] != bb[63]) && (d[63] != aa[63]);
        e.lat = (a >= b) ? 3 : 4;
      end
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one command; returns the cycle count at the negedge before the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, ahi, bhi,
                       output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_a_hi = ahi; cmd_b_hi = bhi;
    sb.push_back(model(op, a, b, ahi, bhi));
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", {63'd0, cmd_ready}, 64'd1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, stall for `stall` cycles.
  task automatic collect(input int acc_cyc, input int stall);
    exp_t e;
    int   n;
    n = 0;
    pass_log.delete();
    rsp_ready = (stall == 0);
    while (!rsp_valid && n < 60) begin
      pass_log.push_back({alu_ctrl, alu_a, alu_b});
      @(negedge clk);
      n++;
    end
    check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
      check("rsp_lo", {32'd0, rsp_lo}, {32'd0, e.lo});
      check("rsp_hi", {32'd0, rsp_hi}, {32'd0, e.hi});
      check("rsp_flags", {61'd0, rsp_carry, rsp_overflow, rsp_err},
            {61'd0, e.carry, e.ovf, e.err});
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_rsp", {rsp_hi, rsp_lo}, {e.hi, e.lo});
        check("stall_ctl", {59'd0, rsp_valid, cmd_ready, rsp_carry, rsp_overflow, rsp_err},
              {59'd0, 1'b1, 1'b0, e.carry, e.ovf, e.err});
      end
      rsp_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_EN
      exp_s_ovf   = exp_s_ovf | e.ovf;
      exp_s_carry = exp_s_carry | e.carry;
`endif
    end
    @(negedge clk);
    check("post_hs", {62'd0, rsp_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});
`ifdef ALU_SEQ_STICKY_EN
    check("sticky", {62'd0, sticky_ovf, sticky_carry}, {62'd0, exp_s_ovf, exp_s_carry});
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          seen;
    logic [66:0] alu_snap;
    logic [2:0]  rop;

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_a_hi = '0; cmd_b_hi = '0;
`ifdef ALU_SEQ_STICKY_EN
    clr_sticky = 1'b0; exp_s_ovf = 1'b0; exp_s_carry = 1'b0;
`endif
    #12;
    check("reset_alu", {alu_ctrl, alu_a, alu_b}, 67'd0);
    check("reset_rsp", {rsp_hi, rsp_lo}, 64'd0);
    check("reset_ctl", {59'd0, rsp_valid, cmd_ready, rsp_carry, rsp_overflow, rsp_err},
          {59'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;

    // ADD carry out of the top bit.
    issue(3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, t); collect(t, 0);
    // Signed overflow, then SLT with a negative operand.
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, t); collect(t, 0);
    issue(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, t); collect(t, 0);
    issue(3'b001, 32'h5, 32'h7, 32'h0, 32'h0, t);          collect(t, 1);
    issue(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 32'h0, t); collect(t, 0);
    issue(3'b011, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h0, 32'h0, t); collect(t, 0);

    // ADD64 with low-word carry: three passes.
    issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, t); collect(t, 0);
    check("add64_npass", 64'(pass_log.size()), 64'd3);
    if (pass_log.size() == 3) begin
      check("add64_p1", pass_log[0], {3'b000, 32'hFFFF_FFFF, 32'h1});
      check("add64_p2", pass_log[1], {3'b000, 32'h0, 32'h0});
      check("add64_p3", pass_log[2], {3'b000, 32'h0, 32'h1});
    end
    // ADD64 without low carry: correction skipped.
    issue(3'b110, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'h1, t); collect(t, 0);

    // SUB64 borrow correction, then signed overflow.
    issue(3'b111, 32'h0, 32'h1, 32'h1, 32'h0, t);          collect(t, 0);
    issue(3'b111, 32'h0, 32'h1, 32'h8000_0000, 32'h0, t);  collect(t, 0);
    issue(3'b111, 32'h9, 32'h3, 32'h0, 32'h1, t);          collect(t, 0);

    // Illegal opcode with response stalled for five cycles.
    alu_snap = {alu_ctrl, alu_a, alu_b};
    issue(3'b100, 32'h1234, 32'h5678, 32'h9, 32'h9, t); collect(t, 5);
    check("ill_alu_hold", {alu_ctrl, alu_a, alu_b}, alu_snap);

    // Random commands with random response stalls.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      issue(rop, $urandom, $urandom, $urandom, $urandom, t);
      collect(t, int'($urandom_range(0, 2)));
    end

    // Reset during PASS2 of an ADD64.
    issue(3'b110, 32'hFFFF_FFFF, 32'h3, 32'h5, 32'h6, t);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
`ifdef ALU_SEQ_STICKY_EN
    exp_s_ovf = 1'b0; exp_s_carry = 1'b0;
    check("rst_sticky", {62'd0, sticky_ovf, sticky_carry}, 64'd0);
`endif
    check("rst_alu", {alu_ctrl, alu_a, alu_b}, 67'd0);
    check("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);
    check("rst_ctl", {59'd0, rsp_valid, cmd_ready, rsp_carry, rsp_overflow, rsp_err},
          {59'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_no_rsp", 64'(seen), 64'd0);
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);

    // Normal operation resumes after reset.
    issue(3'b111, 32'h0, 32'h0, 32'h0, 32'h1, t); collect(t, 0);
`ifdef ALU_SEQ_STICKY_EN
    // Clear wins over a simultaneous handshake.
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, t);
    clr_sticky = 1'b1;
    @(negedge clk); @(negedge clk);
    clr_sticky = 1'b0;
    void'(sb.pop_front());
    exp_s_ovf = 1'b0; exp_s_carry = 1'b0;
    check("sticky_clr", {62'd0, sticky_ovf, sticky_carry}, 64'd0);
`endif
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Master-side controller for the combinational 32-bit ALU. It accepts operation commands over a valid/ready stream and drives the ALU's a/b/control inputs.
- It samples result, overflow and carry, and returns a response over a second valid/ready stream.
- It adds 64-bit ADD/SUB by chaining up to three ALU passes through the existing ALU. The ALU has no carry-in, so the carry is folded in by a +1/-1 correction pass.
- Sits between the datapath issue logic and the ALU.

Parameters:
ALU_WAIT, 0, extra cycles each ALU pass is held before sampling (0 = ALU result captured in the same cycle the operands are driven).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 101 SLT, 110 ADD64, 111 SUB64, 100 illegal
cmd_a  input  32  operand A (low word for 64-bit ops)
cmd_b  input  32  operand B (low word for 64-bit ops)
cmd_a_hi  input  32  operand A high word, 64-bit ops only
cmd_b_hi  input  32  operand B high word, 64-bit ops only
alu_a  output  32  registered ALU operand a
alu_b  output  32  registered ALU operand b
alu_ctrl  output  3  registered ALU control, using the same encoding as cmd_op 000-101
alu_result  input  32  ALU result
alu_overflow  input  1  ALU overflow flag
alu_carry  input  1  ALU carry-out (no-borrow for SUB)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_lo  output  32  result low word
rsp_hi  output  32  result high word; 0 for 32-bit ops
rsp_carry  output  1  carry / no-borrow
rsp_overflow  output  1  signed overflow
rsp_err  output  1  illegal opcode

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0 except cmd_ready = 1 once in IDLE. Any in-flight command is discarded, with no response.
- States: IDLE, PASS1, PASS2, PASS3, RESP.
- cmd_ready = 1 only in IDLE. Commands are captured into internal registers on acceptance.
- Each PASS drives alu_a/alu_b/alu_ctrl for ALU_WAIT+1 cycles, then captures alu_result/alu_carry/alu_overflow at the final cycle's edge.
- IDLE -> PASS1 on accept, for legal ops. Illegal op -> RESP directly with rsp_err = 1 and all other response fields 0.
- 32-bit ops: PASS1 only, then RESP.
  - rsp_carry = alu_carry.
  - rsp_overflow = alu_overflow for ADD/SUB; 0 for AND/XOR/SLT.
  - rsp_hi = 0.
  - Latency with ALU_WAIT = 0: accept at T, rsp_valid at T+2.
- ADD64:
  - PASS1 adds the low words: lo = result, c0 = carry.
  - PASS2 adds the high words: t = result, c1 = carry.
  - If c0 = 1, PASS3 runs ADD t + 1: hi = result, c2 = carry. Otherwise PASS3 is skipped, hi = t and c2 = 0.
  - rsp_carry = c1 | c2.
  - rsp_overflow = (a_hi[31] == b_hi[31]) & (hi[31] != a_hi[31]).
- SUB64:
  - PASS1 subtracts the low words: c0 = no-borrow.
  - PASS2 subtracts the high words: t, c1.
  - If c0 = 0, PASS3 runs SUB t - 1: c2 = carry. Otherwise PASS3 is skipped and c2 = 1.
  - rsp_carry = c1 & c2.
  - rsp_overflow = (a_hi[31] != b_hi[31]) & (hi[31] != a_hi[31]).
- 64-bit latency with ALU_WAIT = 0: rsp_valid at T+3 (PASS3 skipped) or T+4.
- RESP:
  - rsp_valid = 1 and all rsp_* fields are held stable until rsp_ready.
  - On the handshake -> IDLE. The next command cannot be accepted in the same cycle; earliest acceptance is the cycle after.
- alu_* outputs hold their last value outside PASS states.
- Wrap-around: 64-bit results are modulo 2^64, with no saturation.

Optional Feature:
ALU_SEQ_STICKY_EN:
- When defined, adds input clr_sticky (1 bit) plus outputs sticky_ovf and sticky_carry (1 bit each).
- On each response handshake, sticky_ovf and sticky_carry OR in rsp_overflow and rsp_carry.
- clr_sticky = 1 clears both bits. If a handshake sets a bit in the same cycle as clr_sticky, clear wins.
- Reset clears both bits.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, rsp_ready = 1 -> rsp_lo = 0, carry = 1, overflow = 0, rsp_hi = 0, rsp_valid exactly 2 cycles after accept.
- ADD 0x7FFFFFFF + 0x00000001, then SLT 0xFFFFFFFF, 0x00000001 -> first response 0x80000000 with overflow = 1; second rsp_lo = 1 with overflow = 0.
- ADD64 {0x00000000, 0xFFFFFFFF} + {0x00000000, 0x00000001} -> hi = 1, lo = 0, carry = 0, overflow = 0; three ALU passes observed; rsp_valid at T+4.
- SUB64 {0x00000001, 0x00000000} - {0x00000000, 0x00000001} -> hi = 0, lo = 0xFFFFFFFF, carry = 1; then SUB64 {0x80000000, 0} - {0, 1} -> hi = 0x7FFFFFFF, lo = 0xFFFFFFFF, overflow = 1.
- cmd_op = 100 -> rsp_err = 1 at T+1, alu_* unchanged. Next, rsp_ready held low for 5 cycles -> rsp_* stable and cmd_ready = 0 throughout.
- rst_n pulsed low during PASS2 of an ADD64 -> all outputs 0 immediately, no response after release, cmd_ready = 1 on the next clock. With ALU_SEQ_STICKY_EN, sticky bits are also cleared.
